// File: rtl/rotor_bank_if.sv
// ---------------------------------------------------------------------------
// rotor_bank_if
//   Letter handshake bundle between the plugboard and the rotor/reflector stage.
//
//   Valid/ready semantics (both directions): a transfer happens on a rising
//   clk edge where valid and ready are both high. The producer holds valid and
//   its data stable until that edge. The consumer may raise or lower ready at
//   any time, and ready may depend combinationally on other inputs.
//
//   Signals
//     in_valid   plugboard -> stage   in_letter is valid
//     in_ready   stage -> plugboard   stage can take a letter this cycle
//     in_letter  plugboard -> stage   letter index 0..25 (>=26 passes through)
//     out_valid  stage -> plugboard   out_letter is valid
//     out_ready  plugboard -> stage   return path accepts out_letter
//     out_letter stage -> plugboard   enciphered letter index
//
//   Modports
//     master : upstream side (drives the letter in, takes the result back)
//     slave  : the rotor stage
// ---------------------------------------------------------------------------
interface rotor_bank_if;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_letter;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_letter;

    modport master (
        output in_valid,
        output in_letter,
        input  in_ready,
        input  out_valid,
        input  out_letter,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_letter,
        output in_ready,
        output out_valid,
        output out_letter,
        input  out_ready
    );
endinterface

// File: rtl/rotor_bank.sv
// ---------------------------------------------------------------------------
// rotor_bank
//   Enigma rotor/reflector stage sitting behind the plugboard. Each accepted
//   letter first steps the rotors (with the middle-rotor double step), then is
//   passed right->middle->left, through reflector B, and back left->middle->
//   right through the inverse wirings. Wirings are fixed: left = I,
//   middle = II, right = III, reflector = B. There are no ring settings.
//
//   One state per clock:
//     IDLE -> STEP -> FR -> FM -> FL -> RF -> BL -> BM -> BR -> OUT -> IDLE
//   out_valid rises on the eighth edge after the accepting edge, so a new
//   letter can be taken at most once every ten clocks.
//
//   Ports
//     clk        in   1    rising-edge clock
//     rst        in   1    asynchronous active-high reset
//     cfg_load   in   1    load start positions (only honoured in IDLE)
//     cfg_pos    in   15   {L[14:10], M[9:5], R[4:0]}; a field >= 26 loads as 0
//     bus        slave     letter in / letter out handshake (rotor_bank_if)
//     pos_l      out  5    left rotor position   (0..25)
//     pos_m      out  5    middle rotor position (0..25)
//     pos_r      out  5    right rotor position  (0..25)
//     dbg_state  out  4    current FSM state encoding (state_t)
// ---------------------------------------------------------------------------
module rotor_bank #(
    parameter logic [4:0] NOTCH_L = 5'd16,  // Q: left rotor never drives a step
    parameter logic [4:0] NOTCH_M = 5'd4,   // E
    parameter logic [4:0] NOTCH_R = 5'd21   // V
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_load,
    input  logic [14:0]  cfg_pos,
    rotor_bank_if.slave  bus,
    output logic [4:0]   pos_l,
    output logic [4:0]   pos_m,
    output logic [4:0]   pos_r,
    output logic [3:0]   dbg_state
);

    // Notch positions outside the alphabet would make a rotor never turn over.
    if (NOTCH_L > 5'd25 || NOTCH_M > 5'd25 || NOTCH_R > 5'd25) begin : g_bad_notch
        $error("rotor_bank: notch parameter outside 0..25");
    end

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_STEP = 4'd1,
        S_FR   = 4'd2,
        S_FM   = 4'd3,
        S_FL   = 4'd4,
        S_RF   = 4'd5,
        S_BL   = 4'd6,
        S_BM   = 4'd7,
        S_BR   = 4'd8,
        S_OUT  = 4'd9
    } state_t;

    localparam logic [1:0] ROT_L = 2'd0;
    localparam logic [1:0] ROT_M = 2'd1;
    localparam logic [1:0] ROT_R = 2'd2;

    // Forward wirings: entry i is the contact letter reached from contact i.
    // Rotor I   : EKMFLGDQVZNTOWYHXUSPAIBRCJ
    localparam logic [4:0] WIRE_I [26] = '{
        5'd4,  5'd10, 5'd12, 5'd5,  5'd11, 5'd6,  5'd3,  5'd16, 5'd21,
        5'd25, 5'd13, 5'd19, 5'd14, 5'd22, 5'd24, 5'd7,  5'd23, 5'd20,
        5'd18, 5'd15, 5'd0,  5'd8,  5'd1,  5'd17, 5'd2,  5'd9
    };
    // Rotor II  : AJDKSIRUXBLHWTMCQGZNPYFVOE
    localparam logic [4:0] WIRE_II [26] = '{
        5'd0,  5'd9,  5'd3,  5'd10, 5'd18, 5'd8,  5'd17, 5'd20, 5'd23,
        5'd1,  5'd11, 5'd7,  5'd22, 5'd19, 5'd12, 5'd2,  5'd16, 5'd6,
        5'd25, 5'd13, 5'd15, 5'd24, 5'd5,  5'd21, 5'd14, 5'd4
    };
    // Rotor III : BDFHJLCPRTXVZNYEIWGAKMUSQO
    localparam logic [4:0] WIRE_III [26] = '{
        5'd1,  5'd3,  5'd5,  5'd7,  5'd9,  5'd11, 5'd2,  5'd15, 5'd17,
        5'd19, 5'd23, 5'd21, 5'd25, 5'd13, 5'd24, 5'd4,  5'd8,  5'd22,
        5'd6,  5'd0,  5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14
    };
    // Reflector B : YRUHQSLDPXNGOKMIEBFZCWVJAT
    localparam logic [4:0] REFL_B [26] = '{
        5'd24, 5'd17, 5'd20, 5'd7,  5'd16, 5'd18, 5'd11, 5'd3,  5'd15,
        5'd23, 5'd13, 5'd6,  5'd14, 5'd10, 5'd12, 5'd8,  5'd4,  5'd1,
        5'd5,  5'd25, 5'd2,  5'd22, 5'd21, 5'd9,  5'd0,  5'd19
    };

    // (a + b) mod 26 for a, b in 0..25, formed in 6 bits so nothing wraps at 32.
    function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 6'd26) s = s - 6'd26;
        return s[4:0];
    endfunction

    // (a - b) mod 26 for a, b in 0..25; biased by 26 so the 6-bit value stays positive.
    function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] d;
        d = {1'b0, a} + 6'd26 - {1'b0, b};
        if (d >= 6'd26) d = d - 6'd26;
        return d[4:0];
    endfunction

    function automatic logic [4:0] inc26(input logic [4:0] p);
        return (p == 5'd25) ? 5'd0 : p + 5'd1;
    endfunction

    function automatic logic [4:0] clamp26(input logic [4:0] p);
        return (p >= 5'd26) ? 5'd0 : p;
    endfunction

    function automatic logic [4:0] fwd_map(input logic [1:0] sel, input logic [4:0] idx);
        logic [4:0] r;
        case (sel)
            ROT_L:   r = WIRE_I[idx];
            ROT_M:   r = WIRE_II[idx];
            ROT_R:   r = WIRE_III[idx];
            default: r = idx;
        endcase
        return r;
    endfunction

    // Inverse wiring found by searching the forward table, so the two
    // directions can never disagree.
    function automatic logic [4:0] inv_map(input logic [1:0] sel, input logic [4:0] x);
        logic [4:0] r;
        r = 5'd0;
        for (int i = 0; i < 26; i++) begin
            if (fwd_map(sel, 5'(i)) == x) r = 5'(i);
        end
        return r;
    endfunction

    // One rotor traversal: enter at contact (c + p), leave shifted back by p.
    function automatic logic [4:0] rotor_pass(input logic [1:0] sel, input logic [4:0] p,
                                              input logic [4:0] c, input logic inverse);
        logic [4:0] contact;
        logic [4:0] t;
        contact = add26(c, p);
        t = inverse ? inv_map(sel, contact) : fwd_map(sel, contact);
        return sub26(t, p);
    endfunction

    state_t     state_q, state_d;
    logic [4:0] c_q, c_d;
    logic       bypass_q, bypass_d;   // letter >= 26: no stepping, no substitution
    logic [4:0] pl_d, pm_d, pr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            c_q      <= 5'd0;
            bypass_q <= 1'b0;
            pos_l    <= 5'd0;
            pos_m    <= 5'd0;
            pos_r    <= 5'd0;
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            bypass_q <= bypass_d;
            pos_l    <= pl_d;
            pos_m    <= pm_d;
            pos_r    <= pr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        bypass_d = bypass_q;
        pl_d     = pos_l;
        pm_d     = pos_m;
        pr_d     = pos_r;

        case (state_q)
            S_IDLE: begin
                // cfg_load has priority; in_ready is low while it is asserted.
                if (cfg_load) begin
                    pl_d = clamp26(cfg_pos[14:10]);
                    pm_d = clamp26(cfg_pos[9:5]);
                    pr_d = clamp26(cfg_pos[4:0]);
                end else if (bus.in_valid) begin
                    c_d      = bus.in_letter;
                    bypass_d = (bus.in_letter >= 5'd26);
                    state_d  = S_STEP;
                end
            end
            S_STEP: begin
                if (!bypass_q) begin
                    // Middle at its notch steps itself and the left rotor
                    // (double step); otherwise the right notch carries into middle.
                    if (pos_m == NOTCH_M) begin
                        pl_d = inc26(pos_l);
                        pm_d = inc26(pos_m);
                    end else if (pos_r == NOTCH_R) begin
                        pm_d = inc26(pos_m);
                    end
                    pr_d = inc26(pos_r);
                end
                state_d = S_FR;
            end
            S_FR: begin
                if (!bypass_q) c_d = rotor_pass(ROT_R, pos_r, c_q, 1'b0);
                state_d = S_FM;
            end
            S_FM: begin
                if (!bypass_q) c_d = rotor_pass(ROT_M, pos_m, c_q, 1'b0);
                state_d = S_FL;
            end
            S_FL: begin
                if (!bypass_q) c_d = rotor_pass(ROT_L, pos_l, c_q, 1'b0);
                state_d = S_RF;
            end
            S_RF: begin
                if (!bypass_q) c_d = REFL_B[c_q];
                state_d = S_BL;
            end
            S_BL: begin
                if (!bypass_q) c_d = rotor_pass(ROT_L, pos_l, c_q, 1'b1);
                state_d = S_BM;
            end
            S_BM: begin
                if (!bypass_q) c_d = rotor_pass(ROT_M, pos_m, c_q, 1'b1);
                state_d = S_BR;
            end
            S_BR: begin
                if (!bypass_q) c_d = rotor_pass(ROT_R, pos_r, c_q, 1'b1);
                state_d = S_OUT;
            end
            S_OUT: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // in_ready is gated by rst so the upstream never sees a transfer window
    // while the stage is held in reset.
    assign bus.in_ready   = (state_q == S_IDLE) && !cfg_load && !rst;
    assign bus.out_valid  = (state_q == S_OUT);
    assign bus.out_letter = c_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_rotor_bank.sv
`timescale 1ns/1ps
module tb_rotor_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_load;
    logic [14:0] cfg_pos;
    logic [4:0]  pos_l, pos_m, pos_r;
    logic [3:0]  dbg_state;

    rotor_bank_if bus();

    rotor_bank dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_load  (cfg_load),
        .cfg_pos   (cfg_pos),
        .bus       (bus),
        .pos_l     (pos_l),
        .pos_m     (pos_m),
        .pos_r     (pos_r),
        .dbg_state (dbg_state)
    );

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Expected queue entry: bit 5 set = "output must differ from bits 4:0",
    // bit 5 clear = "output must equal bits 4:0".
    logic [5:0] exp_q[$];

    function automatic logic [14:0] p3(input int l, input int m, input int r);
        return {5'(l), 5'(m), 5'(r)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting on the DUT", name);
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready) begin
            n++;
            if (n > 100) begin
                timeout("wait_idle");
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic load_cfg(input logic [14:0] v);
        wait_idle();
        cfg_load = 1'b1;
        cfg_pos  = v;
        @(posedge clk); #1;
        cfg_load = 1'b0;
    endtask

    // Returns #1 after the accepting edge.
    task automatic send(input logic [4:0] l, input logic [5:0] e);
        wait_idle();
        bus.in_valid  = 1'b1;
        bus.in_letter = l;
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                timeout("wait_drain");
                exp_q.delete();
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic check_pos(input string name, input logic [14:0] exp);
        check(name, {pos_l, pos_m, pos_r}, exp);
    endtask

    // ------------------------------------------------------------------
    // Scoreboard monitor: pops one entry per completed output transfer
    // ------------------------------------------------------------------
    initial begin
        logic [5:0] e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0d with nothing expected", bus.out_letter);
                end else begin
                    e = exp_q.pop_front();
                    if (e[5]) begin
                        checks++;
                        if (bus.out_letter == e[4:0]) begin
                            errors++;
                            $display("FAIL self_map: letter %0d enciphered to %0d, must differ",
                                     e[4:0], bus.out_letter);
                        end
                    end else begin
                        check("out_letter", {27'd0, bus.out_letter}, {27'd0, e[4:0]});
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    localparam logic [4:0] WORD_BDZGO [5] = '{5'd1, 5'd3, 5'd25, 5'd6, 5'd14};

    initial begin
        rst           = 1'b1;
        cfg_load      = 1'b0;
        cfg_pos       = '0;
        bus.in_valid  = 1'b0;
        bus.in_letter = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_letter", bus.out_letter, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check_pos("rst_pos", p3(0, 0, 0));
        rst = 1'b0;

        // 1: AAAAA from AAA -> BDZGO, ends at AAF
        load_cfg(p3(0, 0, 0));
        for (int i = 0; i < 5; i++) send(5'd0, {1'b0, WORD_BDZGO[i]});
        wait_drain();
        check_pos("pos_after_aaaaa", p3(0, 0, 5));

        // 2: reciprocity, BDZGO from AAA -> AAAAA
        load_cfg(p3(0, 0, 0));
        for (int i = 0; i < 5; i++) send(WORD_BDZGO[i], 6'd0);
        wait_drain();

        // 2: no letter maps to itself, 26 letters x 26 right positions
        for (int r = 0; r < 26; r++) begin
            for (int x = 0; x < 26; x++) begin
                load_cfg(p3(0, 0, r));
                send(5'(x), {1'b1, 5'(x)});
            end
        end
        wait_drain();

        // 3: double step ADU -> ADV -> AEW -> BFX
        load_cfg(p3(0, 3, 20));
        send(5'd0, {1'b1, 5'd0}); wait_drain(); check_pos("dstep_1", p3(0, 3, 21));
        send(5'd1, {1'b1, 5'd1}); wait_drain(); check_pos("dstep_2", p3(0, 4, 22));
        send(5'd2, {1'b1, 5'd2}); wait_drain(); check_pos("dstep_3", p3(1, 5, 23));
        // right rotor wrap AAZ -> AAA
        load_cfg(p3(0, 0, 25));
        send(5'd0, {1'b1, 5'd0}); wait_drain(); check_pos("r_wrap", p3(0, 0, 0));
        // out-of-range cfg fields load as 0
        load_cfg({5'd30, 5'd2, 5'd27});
        check_pos("cfg_clamp", p3(0, 2, 0));

        // 4: backpressure
        bus.out_ready = 1'b0;
        load_cfg(p3(0, 0, 0));
        send(5'd0, 6'd1);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!bus.out_valid && n < 20) begin
                n++;
                @(negedge clk);
            end
            if (!bus.out_valid) timeout("bp_out_valid");
        end
        bus.in_valid  = 1'b1;   // upstream holding a letter while busy
        bus.in_letter = 5'd7;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_out_letter", bus.out_letter, 1);
            check("bp_in_ready", bus.in_ready, 0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        #1;
        check("bp_release_still_out", bus.out_valid, 1);
        @(posedge clk); #1;
        check("bp_idle_out_valid", bus.out_valid, 0);
        check("bp_idle_in_ready", bus.in_ready, 1);
        wait_drain();
        check_pos("bp_pos", p3(0, 0, 1));

        // 5: latency, accept at edge k -> out_valid after edge k+8 (9th edge counting k)
        load_cfg(p3(0, 0, 0));
        send(5'd0, 6'd1);
        for (int j = 1; j <= 8; j++) begin
            @(posedge clk); #1;
            if (j == 7) check("lat_low_k7", bus.out_valid, 0);
            if (j == 8) check("lat_high_k8", bus.out_valid, 1);
        end
        wait_drain();

        // 5: cfg_load mid-transaction is ignored
        load_cfg(p3(0, 0, 0));
        send(5'd0, 6'd1);
        cfg_load = 1'b1;
        cfg_pos  = p3(5, 5, 5);
        repeat (4) @(posedge clk);
        #1;
        cfg_load = 1'b0;
        wait_drain();
        check_pos("cfg_mid_ignored", p3(0, 0, 1));

        // 5: out-of-range letter passes through, positions untouched
        send(5'd27, 6'd27);
        wait_drain();
        check_pos("bypass_pos", p3(0, 0, 1));

        // 6: async reset in FL
        load_cfg(p3(0, 0, 2));
        send(5'd0, {1'b1, 5'd0});
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_state_fl", dbg_state, 4);
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("async_rst_out_valid", bus.out_valid, 0);
        check("async_rst_in_ready", bus.in_ready, 0);
        check_pos("async_rst_pos", p3(0, 0, 0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        load_cfg(p3(0, 0, 0));
        send(5'd0, 6'd1);
        wait_drain();
        check_pos("post_rst_pos", p3(0, 0, 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
